// File: rtl/calc_ctrl.sv
// Operation sequencer for the 4xW calculator register file: reads operands, runs a
// single-cycle ALU op or a W-cycle shift-add multiply, writes back and pulses done.
module calc_ctrl #(
    parameter int unsigned W = 16
) (
    input  logic         ck,
    input  logic         res,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [1:0]   src_a,
    input  logic [1:0]   src_b,
    input  logic [1:0]   dst,
    input  logic [W-1:0] imm,
    input  logic [W-1:0] rf_q,
    output logic [1:0]   rf_rsel,
    output logic [1:0]   rf_wsel,
    output logic [W-1:0] rf_d,
    output logic         rf_we,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic         zero
);

    localparam int unsigned CW = $clog2(W);
    localparam logic [CW-1:0] CntLast = CW'(W - 1);

    localparam logic [2:0] OpLoad = 3'd0;
    localparam logic [2:0] OpAdd  = 3'd1;
    localparam logic [2:0] OpSub  = 3'd2;
    localparam logic [2:0] OpAnd  = 3'd3;
    localparam logic [2:0] OpOr   = 3'd4;
    localparam logic [2:0] OpXor  = 3'd5;
    localparam logic [2:0] OpMul  = 3'd6;
    localparam logic [2:0] OpMov  = 3'd7;

    typedef enum logic [2:0] {StIdle, StRda, StRdb, StExec, StWb, StDone} state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [2:0]      r_op;
    logic [1:0]      r_src_a;
    logic [1:0]      r_src_b;
    logic [1:0]      r_dst;
    logic [W-1:0]    r_imm;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [2*W-1:0]  r_prod;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_result;
    logic            r_ovf_n;
    logic            r_ovf;
    logic            r_zero;

    logic [W:0]      w_add;
    logic [W:0]      w_sub;
    logic [W:0]      w_mul_sum;
    logic [2*W-1:0]  w_prod_nx;
    logic [W-1:0]    w_res;
    logic            w_ovf;
    logic            w_exec_last;

    // Every op passes through EXEC; LOAD and MOV use it to form their result.
    assign w_exec_last = (r_op != OpMul) || (r_cnt == CntLast);

    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        rf_rsel   = 2'd0;
        rf_we     = 1'b1;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    w_state_d = (op == OpLoad) ? StExec : StRda;
                end
            end
            StRda: begin
                rf_rsel   = r_src_a;
                w_state_d = (r_op == OpMov) ? StExec : StRdb;
            end
            StRdb: begin
                rf_rsel   = r_src_b;
                w_state_d = StExec;
            end
            StExec: begin
                if (w_exec_last) begin
                    w_state_d = StWb;
                end
            end
            StWb: begin
                rf_we     = 1'b0;
                w_state_d = StDone;
            end
            StDone: begin
                done      = 1'b1;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign w_add     = {1'b0, r_a} + {1'b0, r_b};
    assign w_sub     = {1'b0, r_a} - {1'b0, r_b};
    // Shift-add step: add A into the high half when the multiplier LSB is set, shift right.
    assign w_mul_sum = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_a} : {(W + 1){1'b0}});
    assign w_prod_nx = {w_mul_sum, r_prod[W-1:1]};

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (r_op)
            OpLoad: w_res = r_imm;
            OpAdd: begin
                w_res = w_add[W-1:0];
                w_ovf = w_add[W];
            end
            OpSub: begin
                w_res = w_sub[W-1:0];
                w_ovf = w_sub[W];
            end
            OpAnd: w_res = r_a & r_b;
            OpOr:  w_res = r_a | r_b;
            OpXor: w_res = r_a ^ r_b;
            OpMul: begin
                w_res = w_prod_nx[W-1:0];
                w_ovf = |w_prod_nx[2*W-1:W];
            end
            OpMov: w_res = r_a;
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            r_op     <= '0;
            r_src_a  <= '0;
            r_src_b  <= '0;
            r_dst    <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_ovf_n  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            if (r_state == StIdle && start) begin
                r_op    <= op;
                r_src_a <= src_a;
                r_src_b <= src_b;
                r_dst   <= dst;
                r_imm   <= imm;
            end
            if (r_state == StRda) begin
                r_a <= rf_q;
            end
            if (r_state == StRdb) begin
                r_b    <= rf_q;
                r_prod <= {{W{1'b0}}, rf_q};
                r_cnt  <= '0;
            end
            if (r_state == StExec) begin
                if (r_op == OpMul) begin
                    r_prod <= w_prod_nx;
                    r_cnt  <= r_cnt + CW'(1);
                end
                if (w_exec_last) begin
                    r_result <= w_res;
                    r_ovf_n  <= w_ovf;
                end
            end
            if (r_state == StWb) begin
                r_ovf  <= r_ovf_n;
                r_zero <= (r_result == '0);
            end
        end
    end

    assign rf_d    = r_result;
    assign rf_wsel = r_dst;
    assign ovf     = r_ovf;
    assign zero    = r_zero;

endmodule

// File: tb/tb_calc_ctrl.sv
// Bench for calc_ctrl: behavioural 4x16 register file, latency/arithmetic model checked
// every cycle, plus directed commands with hand-computed results.
module tb_calc_ctrl;

    logic        ck = 1'b0;
    logic        res = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [1:0]  src_a = '0;
    logic [1:0]  src_b = '0;
    logic [1:0]  dst = '0;
    logic [15:0] imm = '0;
    logic [15:0] rf_q;
    logic [1:0]  rf_rsel;
    logic [1:0]  rf_wsel;
    logic [15:0] rf_d;
    logic        rf_we;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        zero;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_wr = 0;

    calc_ctrl #(.W(16)) dut (
        .ck(ck), .res(res), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .dst(dst), .imm(imm), .rf_q(rf_q), .rf_rsel(rf_rsel), .rf_wsel(rf_wsel),
        .rf_d(rf_d), .rf_we(rf_we), .busy(busy), .done(done), .ovf(ovf), .zero(zero)
    );

    always #5 ck = ~ck;

    // Register file seen by the DUT.
    logic [15:0] rf [4];
    always @(posedge ck or negedge res) begin
        if (!res) begin
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else if (!rf_we) begin
            rf[rf_wsel] <= rf_d;
        end
    end
    assign rf_q = rf[rf_rsel];

    always @(posedge ck) begin
        if (res) begin
            if (done) n_done <= n_done + 1;
            if (!rf_we) n_wr <= n_wr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each command is a write-back value, a flag and the cycle index of its write.
    typedef struct packed {
        int          lat;
        logic [15:0] val;
        logic        ovf;
    } exp_t;

    function automatic exp_t predict(input logic [2:0] o, input logic [15:0] a,
                                     input logic [15:0] b, input logic [15:0] im);
        exp_t e;
        logic [31:0] p;
        e.lat = 4;
        e.ovf = 1'b0;
        e.val = '0;
        case (o)
            3'd0: begin e.lat = 2; e.val = im; end
            3'd1: begin p = 32'(a) + 32'(b); e.val = p[15:0]; e.ovf = p[16]; end
            3'd2: begin e.val = a - b; e.ovf = (a < b); end
            3'd3: e.val = a & b;
            3'd4: e.val = a | b;
            3'd5: e.val = a ^ b;
            3'd6: begin p = 32'(a) * 32'(b); e.lat = 19; e.val = p[15:0]; e.ovf = |p[31:16]; end
            default: begin e.lat = 3; e.val = a; end
        endcase
        return e;
    endfunction

    logic [15:0] m_rf [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
    int          m_t = -1;
    exp_t        m_exp = '{0, 16'h0, 1'b0};
    logic [1:0]  m_dst = '0;
    logic        m_ovf = 1'b0;
    logic        m_zero = 1'b0;

    always @(posedge ck or negedge res) begin
        if (!res) begin
            m_t    <= -1;
            m_ovf  <= 1'b0;
            m_zero <= 1'b0;
            for (int i = 0; i < 4; i++) m_rf[i] <= '0;
        end else if (m_t < 0) begin
            if (start) begin
                m_exp <= predict(op, m_rf[src_a], m_rf[src_b], imm);
                m_dst <= dst;
                m_t   <= 1;
            end
        end else begin
            if (m_t == m_exp.lat) begin
                m_rf[m_dst] <= m_exp.val;
                m_ovf       <= m_exp.ovf;
                m_zero      <= (m_exp.val == 16'h0);
            end
            m_t <= (m_t == m_exp.lat + 1) ? -1 : m_t + 1;
        end
    end

    always @(negedge ck) begin
        chk("busy", 32'(busy), 32'(m_t >= 1));
        chk("done", 32'(done), 32'(m_t >= 0 && m_t == m_exp.lat + 1));
        chk("rf_we", 32'(rf_we), 32'(m_t != m_exp.lat));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("zero", 32'(zero), 32'(m_zero));
        if (m_t == m_exp.lat) begin
            chk("rf_wsel", 32'(rf_wsel), 32'(m_dst));
            chk("rf_d", 32'(rf_d), 32'(m_exp.val));
        end
        if (m_t < 0 || m_t >= m_exp.lat) chk("rf_rsel_idle", 32'(rf_rsel), 32'd0);
    end

    task automatic run(input logic [2:0] o, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] d, input logic [15:0] im, input int exp_done,
                       input int poke, input int rst_at);
        int k;
        int nd0;
        int nw0;
        @(negedge ck);
        op = o; src_a = a; src_b = b; dst = d; imm = im; start = 1'b1;
        nd0 = n_done;
        nw0 = n_wr;
        @(posedge ck);
        k = 0;
        while (k < 40) begin
            @(negedge ck);
            k++;
            start = (k == poke);
            if (k == poke) begin
                op = 3'd0; dst = 2'd0; imm = 16'hFFFF;
            end
            if (k == rst_at) begin
                #2 res = 1'b0;
                #1;
                chk("rst_we", 32'(rf_we), 32'd1);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_ovf", 32'(ovf), 32'd0);
                chk("rst_zero", 32'(zero), 32'd0);
                chk("rst_rf_d", 32'(rf_d), 32'd0);
                @(negedge ck);
                @(negedge ck);
                chk("rst_no_wb", 32'(n_wr - nw0), 32'd0);
                res = 1'b1;
                return;
            end
            if (done) break;
        end
        chk("done_cycle", 32'(k), 32'(exp_done));
        @(posedge ck);
        #1;
        if (poke >= 0) begin
            chk("one_done", 32'(n_done - nd0), 32'd1);
            chk("one_write", 32'(n_wr - nw0), 32'd1);
        end
    endtask

    task automatic post(input int d, input logic [15:0] v, input logic o, input logic z);
        chk("rf_val", 32'(rf[d]), 32'(v));
        chk("flag_ovf", 32'(ovf), 32'(o));
        chk("flag_zero", 32'(zero), 32'(z));
        for (int i = 0; i < 4; i++) chk("rf_vs_model", 32'(rf[i]), 32'(m_rf[i]));
    endtask

    initial begin
        #12;
        chk("reset_we", 32'(rf_we), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_rsel", 32'(rf_rsel), 32'd0);
        chk("reset_wsel", 32'(rf_wsel), 32'd0);
        chk("reset_d", 32'(rf_d), 32'd0);
        chk("reset_flags", 32'({ovf, zero}), 32'd0);
        @(negedge ck);
        res = 1'b1;

        run(3'd0, 2'd0, 2'd0, 2'd1, 16'h1234, 3, -1, -1); post(1, 16'h1234, 1'b0, 1'b0);
        run(3'd1, 2'd1, 2'd1, 2'd2, 16'h0, 5, -1, -1);    post(2, 16'h2468, 1'b0, 1'b0);
        run(3'd0, 2'd0, 2'd0, 2'd2, 16'h8000, 3, -1, -1); post(2, 16'h8000, 1'b0, 1'b0);
        run(3'd1, 2'd2, 2'd2, 2'd2, 16'h0, 5, -1, -1);    post(2, 16'h0000, 1'b1, 1'b1);
        run(3'd2, 2'd0, 2'd1, 2'd3, 16'h0, 5, -1, -1);    post(3, 16'hEDCC, 1'b1, 1'b0);
        run(3'd5, 2'd3, 2'd3, 2'd3, 16'h0, 5, -1, -1);    post(3, 16'h0000, 1'b0, 1'b1);
        run(3'd0, 2'd0, 2'd0, 2'd0, 16'd300, 3, -1, -1);  post(0, 16'd300, 1'b0, 1'b0);
        run(3'd0, 2'd0, 2'd0, 2'd1, 16'd200, 3, -1, -1);  post(1, 16'd200, 1'b0, 1'b0);
        run(3'd6, 2'd0, 2'd1, 2'd2, 16'h0, 20, -1, -1);   post(2, 16'hEA60, 1'b0, 1'b0);
        run(3'd0, 2'd0, 2'd0, 2'd3, 16'h0100, 3, -1, -1); post(3, 16'h0100, 1'b0, 1'b0);
        run(3'd6, 2'd3, 2'd3, 2'd0, 16'h0, 20, -1, -1);   post(0, 16'h0000, 1'b1, 1'b1);

        // Reset in the middle of a multiply: no write-back, everything cleared.
        run(3'd6, 2'd3, 2'd3, 2'd2, 16'h0, 20, -1, 10);
        chk("rst_rf2", 32'(rf[2]), 32'd0);
        run(3'd0, 2'd0, 2'd0, 2'd1, 16'h00C8, 3, -1, -1); post(1, 16'h00C8, 1'b0, 1'b0);

        // Second start during a busy multiply must be dropped.
        run(3'd6, 2'd1, 2'd1, 2'd3, 16'h0, 20, 8, -1);    post(3, 16'h9C40, 1'b0, 1'b0);
        chk("poke_no_load", 32'(rf[0]), 32'd0);
        run(3'd7, 2'd3, 2'd0, 2'd1, 16'h0, 4, -1, -1);    post(1, 16'h9C40, 1'b0, 1'b0);
        run(3'd3, 2'd3, 2'd1, 2'd2, 16'h0, 5, -1, -1);    post(2, 16'h9C40, 1'b0, 1'b0);
        run(3'd4, 2'd0, 2'd2, 2'd0, 16'h0, 5, -1, -1);    post(0, 16'h9C40, 1'b0, 1'b0);

        @(negedge ck);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
